operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/definitions_pkg.sv | 27 ++
 rtl/operand_loader_btn_debounce.sv | 71 +++++++
 rtl/operand_loader.sv | 96 +++++++++
 tb/tb_operand_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared types and constants for the operand loader and its multiplier.
package definitions_pkg;

  // Signed 8-bit operand as seen on the board switches and the multiplier ports.
  typedef logic signed [7:0] int8_t;

  // Coarse state of the multiplier datapath this loader feeds.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1
  } state_e;

  // Loader sequencing states; the encoding is driven straight onto the LEDs.
  typedef enum logic [2:0] {
    LOAD_MC   = 3'd0,
    LOAD_MP   = 3'd1,
    ARM       = 3'd2,
    START     = 3'd3,
    WAIT_ACK  = 3'd4,
    WAIT_DONE = 3'd5
  } loader_state_e;

  // Cycles to wait for the multiplier to drop ready before declaring the start lost.
  localparam int LOADER_ACK_TIMEOUT = 256;
  localparam int ACK_CNT_W          = $clog2(LOADER_ACK_TIMEOUT);

endpackage

// File: rtl/operand_loader_btn_debounce.sv
// Pushbutton front end: 2-flop synchronizer, optional debounce filter and
// rising-edge detector producing a one-cycle press pulse.
// Optional filter enabled by defining OPERAND_LOADER_DEBOUNCE_EN.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  logic       sync1;
  logic       sync2;
  logic [1:0] fill;   // marks when sync2 holds a real sample rather than its reset value
  logic       level;  // filtered button level
  logic       prev;
  logic       armed;  // set once the button has been seen released after reset

  // Two-stage synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      fill  <= 2'b00;
    end else begin
      // NOTE: non-blocking so each flop samples the previous stage's old value.
      sync1 <= i_btn;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
    end
  end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  // No filter: the synchronized level is used as is; the parameter folds away.
  assign level = sync2 | (DEBOUNCE_CYCLES < 0);
`endif

  // Edge detector, held off until a genuine released level has been observed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev <= level;
      if (fill[1] && !sync2 && !level) armed <= 1'b1;
    end
  end

  assign o_press = level & ~prev & armed;

endmodule

// File: rtl/operand_loader.sv
// Loads two signed operands from the switches on successive button presses,
// then issues a one-cycle start to the multiplier and tracks it to completion.
// Optional button debounce enabled by defining OPERAND_LOADER_DEBOUNCE_EN.
module operand_loader
  import definitions_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  int8_t         i_switches,
  input  logic          i_btn_load,
  input  logic          i_rdy,
  output int8_t         o_multiplicand,
  output int8_t         o_multiplier,
  output logic          o_start,
  output logic          o_busy,
  output loader_state_e o_stage
);

  localparam logic [ACK_CNT_W-1:0] ACK_LAST = ACK_CNT_W'(LOADER_ACK_TIMEOUT - 1);

  logic                 press;
  logic [ACK_CNT_W-1:0] ack_cnt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (i_btn_load),
    .o_press(press)
  );

  // Sequencing FSM; state and all outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_stage        <= LOAD_MC;
      o_multiplicand <= '0;
      o_multiplier   <= '0;
      o_start        <= 1'b0;
      o_busy         <= 1'b0;
      ack_cnt        <= '0;
    end else begin
      case (o_stage)
        LOAD_MC: begin
          if (press) begin
            o_multiplicand <= i_switches;
            o_stage        <= LOAD_MP;
          end
        end
        LOAD_MP: begin
          if (press) begin
            o_multiplier <= i_switches;
            o_stage      <= ARM;
          end
        end
        ARM: begin
          // A press while the multiplier is still busy is simply discarded.
          if (press && i_rdy) begin
            o_stage <= START;
            o_start <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        START: begin
          o_start <= 1'b0;
          ack_cnt <= '0;
          o_stage <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!i_rdy) begin
            o_stage <= WAIT_DONE;
          end else if (ack_cnt == ACK_LAST) begin
            // Multiplier never acknowledged the start: give up and reload.
            o_stage <= LOAD_MC;
            o_busy  <= 1'b0;
          end
          if (ack_cnt != '1) ack_cnt <= ack_cnt + ACK_CNT_W'(1);
        end
        WAIT_DONE: begin
          if (i_rdy) begin
            o_stage <= LOAD_MC;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          o_stage <= LOAD_MC;
          o_start <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader.
module tb_operand_loader;
  import definitions_pkg::*;

  localparam int DEB = 16;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int HOLD = 30;
`else
  localparam int HOLD = 4;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn = 1'b0;
  logic          rdy = 1'b1;
  int8_t         sw  = '0;
  int8_t         mc;
  int8_t         mp;
  logic          start;
  logic          busy;
  loader_state_e stage;

  int vectors     = 0;
  int miscompares = 0;
  int start_pulses = 0;
  int start_cycles = 0;
  int ack_cycles   = 0;

  operand_loader #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_switches    (sw),
    .i_btn_load    (btn),
    .i_rdy         (rdy),
    .o_multiplicand(mc),
    .o_multiplier  (mp),
    .o_start       (start),
    .o_busy        (busy),
    .o_stage       (stage)
  );

  always #5 clk = ~clk;

  // Event monitors sampled on the falling edge.
  always @(negedge clk) begin
    if (start) start_pulses++;
    if (stage == START) start_cycles++;
    if (stage == WAIT_ACK) ack_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int8_t v);
    sw  = v;
    btn = 1'b1;
    repeat (HOLD) tick();
    btn = 1'b0;
    repeat (HOLD) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vectors++; if (mc !== 8'h00) begin miscompares++; $display("FAIL reset_mc: got %h want 00", mc); end
    vectors++; if (mp !== 8'h00) begin miscompares++; $display("FAIL reset_mp: got %h want 00", mp); end
    vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b want 0", start); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (stage !== LOAD_MC) begin miscompares++; $display("FAIL reset_stage: got %0d want %0d", stage, LOAD_MC); end
    rst = 1'b1;
    repeat (5) tick();
    vectors++; if (stage !== LOAD_MC) begin miscompares++; $display("FAIL idle_stage: got %0d want %0d", stage, LOAD_MC); end
  endtask

  task automatic test_load_and_start();
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    press(8'sd7);
`else
    // Synchronizer takes two edges, the register update one more.
    sw  = 8'sd7;
    btn = 1'b1;
    tick(); tick();
    vectors++; if (stage !== LOAD_MC) begin miscompares++; $display("FAIL latency_early: got %0d want %0d", stage, LOAD_MC); end
    tick();
    btn = 1'b0;
    repeat (HOLD) tick();
`endif
    vectors++; if (stage !== LOAD_MP) begin miscompares++; $display("FAIL mc_stage: got %0d want %0d", stage, LOAD_MP); end
    vectors++; if (mc !== 8'h07) begin miscompares++; $display("FAIL mc_value: got %h want 07", mc); end
    press(-8'sd3);
    vectors++; if (stage !== ARM) begin miscompares++; $display("FAIL mp_stage: got %0d want %0d", stage, ARM); end
    vectors++; if (mp !== 8'hFD) begin miscompares++; $display("FAIL mp_value: got %h want FD", mp); end
    sw = 8'h55;
    tick();
    vectors++; if (mc !== 8'h07 || mp !== 8'hFD) begin miscompares++; $display("FAIL arm_hold: got %h/%h want 07/FD", mc, mp); end
    start_pulses = 0;
    start_cycles = 0;
    rdy = 1'b1;
    press(8'h55);
    vectors++; if (start_pulses !== 1) begin miscompares++; $display("FAIL start_pulses: got %0d want 1", start_pulses); end
    vectors++; if (start_cycles !== 1) begin miscompares++; $display("FAIL start_cycles: got %0d want 1", start_cycles); end
    vectors++; if (stage !== WAIT_ACK) begin miscompares++; $display("FAIL ack_stage: got %0d want %0d", stage, WAIT_ACK); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ack_busy: got %b want 1", busy); end
    vectors++; if (mc !== 8'h07 || mp !== 8'hFD) begin miscompares++; $display("FAIL ack_operands: got %h/%h want 07/FD", mc, mp); end
  endtask

  task automatic test_done();
    logic held;
    held = 1'b1;
    rdy = 1'b0;
    tick();
    vectors++; if (stage !== WAIT_DONE) begin miscompares++; $display("FAIL done_stage: got %0d want %0d", stage, WAIT_DONE); end
    repeat (9) begin
      tick();
      if (busy !== 1'b1 || stage !== WAIT_DONE) held = 1'b0;
    end
    vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL done_busy_held: got %b want 1", held); end
    rdy = 1'b1;
    tick();
    vectors++; if (stage !== LOAD_MC) begin miscompares++; $display("FAIL done_return: got %0d want %0d", stage, LOAD_MC); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL done_busy_clear: got %b want 0", busy); end
    vectors++; if (mc !== 8'h07 || mp !== 8'hFD) begin miscompares++; $display("FAIL done_operands: got %h/%h want 07/FD", mc, mp); end
  endtask

  task automatic test_arm_not_ready();
    press(8'h80);
    vectors++; if (mc !== 8'h80) begin miscompares++; $display("FAIL mc_min: got %h want 80", mc); end
    press(8'sd127);
    rdy = 1'b0;
    start_pulses = 0;
    press(8'h00);
    vectors++; if (stage !== ARM) begin miscompares++; $display("FAIL notrdy_stage: got %0d want %0d", stage, ARM); end
    vectors++; if (start_pulses !== 0) begin miscompares++; $display("FAIL notrdy_start: got %0d want 0", start_pulses); end
    rdy = 1'b1;
    ack_cycles = 0;
    press(8'h00);
    vectors++; if (start_pulses !== 1) begin miscompares++; $display("FAIL rdy_start: got %0d want 1", start_pulses); end
  endtask

  task automatic test_timeout();
    int guard;
    guard = 0;
    while (stage == WAIT_ACK && guard < 400) begin
      tick();
      guard++;
    end
    vectors++; if (guard >= 400) begin miscompares++; $display("FAIL timeout_wait: got %0d cycles want exit before 400", guard); end
    vectors++; if (ack_cycles !== 256) begin miscompares++; $display("FAIL timeout_len: got %0d want 256", ack_cycles); end
    vectors++; if (stage !== LOAD_MC) begin miscompares++; $display("FAIL timeout_stage: got %0d want %0d", stage, LOAD_MC); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL timeout_busy: got %b want 0", busy); end
    vectors++; if (mc !== 8'h80 || mp !== 8'h7F) begin miscompares++; $display("FAIL timeout_operands: got %h/%h want 80/7F", mc, mp); end
  endtask

  task automatic test_reset_abort();
    press(8'sd1);
    press(8'sd2);
    press(8'sd0);
    rdy = 1'b0;
    tick();
    vectors++; if (stage !== WAIT_DONE) begin miscompares++; $display("FAIL abort_pre: got %0d want %0d", stage, WAIT_DONE); end
    btn = 1'b1;
    repeat (HOLD) tick();
    rst = 1'b0;
    #1;
    vectors++; if (mc !== 8'h00 || mp !== 8'h00) begin miscompares++; $display("FAIL abort_operands: got %h/%h want 00/00", mc, mp); end
    vectors++; if (start !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_ctrl: got %b/%b want 0/0", start, busy); end
    vectors++; if (stage !== LOAD_MC) begin miscompares++; $display("FAIL abort_stage: got %0d want %0d", stage, LOAD_MC); end
    rdy = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    start_pulses = 0;
    repeat (3 * HOLD + 10) tick();
    vectors++; if (stage !== LOAD_MC || mc !== 8'h00) begin miscompares++; $display("FAIL held_no_press: got stage %0d mc %h want %0d 00", stage, mc, LOAD_MC); end
    btn = 1'b0;
    repeat (HOLD) tick();
    press(8'sd9);
    vectors++; if (stage !== LOAD_MP || mc !== 8'h09) begin miscompares++; $display("FAIL repress: got stage %0d mc %h want %0d 09", stage, mc, LOAD_MP); end
    vectors++; if (start_pulses !== 0) begin miscompares++; $display("FAIL abort_no_start: got %0d want 0", start_pulses); end
  endtask

  task automatic test_glitch();
    sw = 8'h21;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    repeat (3) begin
      btn = 1'b1;
      repeat (5) tick();
      btn = 1'b0;
      repeat (5) tick();
    end
    repeat (20) tick();
    vectors++; if (stage !== LOAD_MP || mp !== 8'h00) begin miscompares++; $display("FAIL glitch_reject: got stage %0d mp %h want %0d 00", stage, mp, LOAD_MP); end
    btn = 1'b1;
    repeat (20) tick();
    btn = 1'b0;
    repeat (30) tick();
`else
    // Without the filter a single-cycle pulse is a press.
    btn = 1'b1;
    tick();
    btn = 1'b0;
    repeat (6) tick();
`endif
    vectors++; if (stage !== ARM) begin miscompares++; $display("FAIL glitch_press_stage: got %0d want %0d", stage, ARM); end
    vectors++; if (mp !== 8'h21) begin miscompares++; $display("FAIL glitch_press_mp: got %h want 21", mp); end
    sw = 8'h44;
    repeat (3) tick();
    vectors++; if (mp !== 8'h21 || mc !== 8'h09) begin miscompares++; $display("FAIL glitch_stable: got %h/%h want 09/21", mc, mp); end
  endtask

  initial begin
    test_reset();
    test_load_and_start();
    test_done();
    test_arm_not_ready();
    test_timeout();
    test_reset_abort();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
